slow_clock_monitor: RTL

Fast-domain monitor for a divided clock. Synchronizes the slow clock (nominal 50 MHz / 22) back into the 50 MHz domain, emits single-cycle edge ticks, measures each slow period in fast cycles, and reports lock and a sticky fault. It sits beside the clock divider and gives downstream slow-rate logic clean ticks plus a health check of the divided clock.

---
 rtl/slow_clock_monitor.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/slow_clock_monitor.sv
// rtl/slow_clock_monitor.sv - synchronizes a divided clock, emits edge ticks, measures its period, reports lock and fault
module slow_clock_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int EXP_PERIOD  = 22,
    parameter int TOLERANCE   = 1,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT     = 44,
    parameter int CNT_W       = 8
) (
    input  logic             FiftyIn,
    input  logic             Resetn,
    input  logic             SlowIn,
    input  logic             ClearFault,
    output logic             RiseTick,
    output logic             FallTick,
    output logic [CNT_W-1:0] Period,
    output logic             PeriodValid,
    output logic             Locked,
    output logic             Fault
);

    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]  PER_MIN     = CNT_W'(EXP_PERIOD - TOLERANCE);
    localparam logic [CNT_W-1:0]  PER_MAX     = CNT_W'(EXP_PERIOD + TOLERANCE);
    localparam logic [CNT_W-1:0]  TMO         = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   rise;
    logic                   fall;

    state_t             state_q, state_d;
    logic [GOOD_W-1:0]  good_q, good_d, good_inc;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               period_good;
    logic               stall;
    logic               publish;
    logic               fault_set;

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & hist_q;

    always_ff @(posedge FiftyIn) begin
        if (!Resetn) begin
            sync_q   <= '0;
            hist_q   <= 1'b0;
            RiseTick <= 1'b0;
            FallTick <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], SlowIn};
            hist_q   <= sync_q[SYNC_STAGES-1];
            RiseTick <= rise;
            FallTick <= fall;
        end
    end

    // cnt_q restarts at 1 on a rise so that at the next rise it equals the period directly
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    assign good_inc    = good_q + GOOD_W'(1);
    assign period_good = (cnt_q >= PER_MIN) && (cnt_q <= PER_MAX);
    assign stall       = (cnt_q >= TMO);

    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        cnt_d     = cnt_q;
        publish   = 1'b0;
        fault_set = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = ST_ACQUIRE;
                    good_d  = '0;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_ACQUIRE: begin
                if (rise) begin
                    publish = 1'b1;
                    cnt_d   = CNT_ONE;
                    if (period_good) begin
                        good_d = good_inc;
                        if (good_inc == GOOD_TARGET) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        good_d = '0;
                    end
                end else if (stall) begin
                    state_d = ST_SEARCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_LOCKED: begin
                if (rise) begin
                    publish = 1'b1;
                    cnt_d   = CNT_ONE;
                    if (!period_good) begin
                        fault_set = 1'b1;
                        state_d   = ST_ACQUIRE;
                        good_d    = '0;
                    end
                end else if (stall) begin
                    fault_set = 1'b1;
                    state_d   = ST_SEARCH;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                good_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge FiftyIn) begin
        if (!Resetn) begin
            state_q     <= ST_SEARCH;
            good_q      <= '0;
            cnt_q       <= '0;
            Period      <= '0;
            PeriodValid <= 1'b0;
            Locked      <= 1'b0;
            Fault       <= 1'b0;
        end else begin
            state_q     <= state_d;
            good_q      <= good_d;
            cnt_q       <= cnt_d;
            PeriodValid <= publish;
            Locked      <= (state_d == ST_LOCKED);
            if (publish) begin
                Period <= cnt_q;
            end
            if (fault_set) begin
                Fault <= 1'b1;
            end else if (ClearFault) begin
                Fault <= 1'b0;
            end
        end
    end

endmodule
